// File: rtl/range_chk_pkg.sv
// Shared types for the range pair checker: result codes, result-stage
// states and the (bound, value) pair record.
package range_chk_pkg;

    // Result code carried on res_code.
    typedef enum logic [1:0] {
        RC_PASS      = 2'd0,
        RC_BOUND_ERR = 2'd1,
        RC_RANGE_ERR = 2'd2,
        RC_ZERO_ERR  = 2'd3
    } res_code_e;

    // Occupancy of the single-entry result register.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_e;

    localparam int PAIR_W = 8;

    // One stimulus pair at the default data width.
    typedef struct packed {
        logic [PAIR_W-1:0] bound;
        logic [PAIR_W-1:0] value;
    } pair_t;

    // Any code other than PASS counts as a failure.
    function automatic logic code_is_fail(input res_code_e code);
        return code != RC_PASS;
    endfunction

endpackage

// File: rtl/range_pair_classify.sv
// Purely combinational classification of one (bound, value) pair against
// the generation rules. All comparisons are unsigned at width W.
module range_pair_classify
    import range_chk_pkg::*;
#(
    parameter int W      = 8,
    parameter int LO_MIN = 3,
    parameter int THRESH = 10
) (
    input  logic [W-1:0] bound,
    input  logic [W-1:0] value,
    output res_code_e    code
);

    localparam logic [W-1:0] LO_MIN_V = W'(LO_MIN);
    localparam logic [W-1:0] THRESH_V = W'(THRESH);

    // Priority-ordered rule check: bound floor first, then range or zero mode.
    always_comb begin
        code = RC_PASS;
        if (bound <= LO_MIN_V) begin
            code = RC_BOUND_ERR;
        end else if (bound > THRESH_V) begin
            if (value < bound) begin
                code = RC_RANGE_ERR;
            end
        end else if (value != '0) begin
            code = RC_ZERO_ERR;
        end
    end

endmodule

// File: rtl/range_pair_checker.sv
// Consumer-side checker for constrained-random (bound, value) pairs.
// Classifies each accepted pair, returns one registered result per pair
// over a valid/ready stream, and keeps saturating pass/fail counters and a
// sticky error flag. Defining RANGE_CHK_CAPTURE_EN adds a capture of the
// first failing pair (cap_valid/cap_bound/cap_value/cap_code).
module range_pair_checker
    import range_chk_pkg::*;
#(
    parameter int W      = 8,
    parameter int LO_MIN = 3,
    parameter int THRESH = 10,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_bound,
    input  logic [W-1:0]     in_value,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_code,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky
`ifdef RANGE_CHK_CAPTURE_EN
    ,
    output logic             cap_valid,
    output logic [W-1:0]     cap_bound,
    output logic [W-1:0]     cap_value,
    output logic [1:0]       cap_code
`endif
);

    res_state_e state_q;
    res_state_e state_d;
    res_code_e  cls_code;
    res_code_e  code_p0;
    logic       accept;
    logic       cls_fail;

    // Saturating increment: a counter at its maximum stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    range_pair_classify #(
        .W      (W),
        .LO_MIN (LO_MIN),
        .THRESH (THRESH)
    ) u_classify (
        .bound (in_bound),
        .value (in_value),
        .code  (cls_code)
    );

    assign cls_fail  = code_is_fail(cls_code);
    assign res_valid = (state_q == ST_FULL);
    assign in_ready  = !res_valid || res_ready;
    assign accept    = in_valid && in_ready;
    assign res_code  = code_p0;

    // Result-stage occupancy: fills on accept, drains on consume.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = ST_FULL;
        end else if (state_q == ST_FULL && res_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Result-stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result code register; only loads on accept so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_p0 <= RC_PASS;
        end else if (accept) begin
            code_p0 <= cls_code;
        end
    end

    // Pass/fail counters count accepts; clear wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clear) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (accept) begin
            if (cls_fail) begin
                fail_cnt <= sat_inc(fail_cnt);
            end else begin
                pass_cnt <= sat_inc(pass_cnt);
            end
        end
    end

    // Sticky error flag set by the first failing accept outside a clear cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (clear) begin
            err_sticky <= 1'b0;
        end else if (accept && cls_fail) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef RANGE_CHK_CAPTURE_EN
    // Capture the first failing pair after reset or clear and hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid <= 1'b0;
            cap_bound <= '0;
            cap_value <= '0;
            cap_code  <= '0;
        end else if (clear) begin
            cap_valid <= 1'b0;
            cap_bound <= '0;
            cap_value <= '0;
            cap_code  <= '0;
        end else if (accept && cls_fail && !cap_valid) begin
            cap_valid <= 1'b1;
            cap_bound <= in_bound;
            cap_value <= in_value;
            cap_code  <= cls_code;
        end
    end
`endif

endmodule
